// File: rtl/sdp_rd_addrgen.sv
// Burst read-address generator: expands {length, start} commands into a stream of
// consecutive addresses with eot on the last one. Define SDP_RD_ADDRGEN_WRAP_EN for circular
// addressing modulo DEPTH.
module sdp_rd_addrgen #(
  parameter int unsigned W_ADDR = 16,
  parameter int unsigned W_LEN  = 16,
  parameter int unsigned DEPTH  = 2**W_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  // command consumer
  input  logic                    cmd_if_valid_i,
  output logic                    cmd_if_ready_o,
  input  logic [W_LEN+W_ADDR-1:0] cmd_if_data_i,
  // address producer
  output logic                    addr_if_valid_o,
  input  logic                    addr_if_ready_i,
  output logic [W_ADDR:0]         addr_if_data_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [W_ADDR-1:0]   addr_q, addr_d;
  logic [W_LEN-1:0]    cnt_q, cnt_d;
  logic [W_ADDR-1:0]   addr_inc;
  logic [W_ADDR-1:0]   cmd_start;
  logic [W_LEN-1:0]    cmd_len;
  logic                last;
  logic                load;
  logic                cmd_ready;

  if (DEPTH == 0 || DEPTH > (2**W_ADDR)) begin : g_depth_check
    $error("sdp_rd_addrgen: DEPTH must be in 1..2**W_ADDR");
  end

  assign cmd_start = cmd_if_data_i[W_ADDR-1:0];
  assign cmd_len   = cmd_if_data_i[W_LEN+W_ADDR-1:W_ADDR];
  assign last      = (cnt_q == '0);

`ifdef SDP_RD_ADDRGEN_WRAP_EN
  localparam logic [W_ADDR-1:0] LastAddr = W_ADDR'(DEPTH - 1);
  assign addr_inc = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
`else
  assign addr_inc = addr_q + 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    cmd_ready       = 1'b0;
    addr_if_valid_o = 1'b0;
    load            = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        load      = cmd_if_valid_i;
      end
      StRun: begin
        addr_if_valid_o = 1'b1;
        // a new command may only slip in on the final handshake, keeping the stream gap-free
        cmd_ready       = last & addr_if_ready_i;
        if (addr_if_ready_i) begin
          if (!last) begin
            addr_d = addr_inc;
            cnt_d  = cnt_q - 1'b1;
          end else if (cmd_if_valid_i) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (cmd_len == '0) begin
        state_d = StIdle;
      end else begin
        addr_d  = cmd_start;
        cnt_d   = cmd_len - 1'b1;
        state_d = StRun;
      end
    end
  end

  // Held low during reset so nothing is accepted while the flops are cleared.
  assign cmd_if_ready_o = cmd_ready & rst;
  assign addr_if_data_o = {last, addr_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/sdp_rd_addrgen.md
# sdp_rd_addrgen

Read-address generator for a simple-dual-port memory read path. It consumes burst commands (start address, length) on a DTI consumer interface and expands each into a stream of consecutive addresses on a DTI producer interface, tagging the last address with eot. It sits directly upstream of the memory read port. The low W_ADDR bits of its address output drive the read port's address input; eot is forwarded alongside the read data.

## Interface
Parameters:
- W_ADDR, 16, address width
- W_LEN, 16, burst length field width
- DEPTH, 2**W_ADDR, memory depth in words; used only when the wrap feature is compiled in

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cmd_if  dti.consumer  W_LEN+W_ADDR  command: data[W_ADDR-1:0] = start address, data[W_LEN+W_ADDR-1:W_ADDR] = length in words
- addr_if  dti.producer  W_ADDR+1  address stream: data[W_ADDR-1:0] = address, data[W_ADDR] = eot (last address of burst)

## Operation
- Two-state FSM: IDLE, RUN.
- Registers: addr (W_ADDR), remaining count cnt (W_LEN), state.
- IDLE:
  - cmd_if.ready = 1.
  - On cmd_if.valid with len == 0: the command is consumed, no address is produced, and the FSM stays in IDLE.
  - On cmd_if.valid with len > 0: addr <= start, cnt <= len-1, go to RUN.
- RUN:
  - addr_if.valid = 1.
  - addr_if.data = {cnt == 0, addr}.
  - On handshake (valid & ready) with cnt != 0: addr <= addr + 1, cnt <= cnt - 1.
  - On handshake with cnt == 0 (last): if the back-to-back condition holds, load the new command; otherwise go to IDLE.
- Back-to-back: in RUN, cmd_if.ready = (cnt == 0) & addr_if.ready.
  - A command accepted on the last handshake is loaded exactly as in IDLE. A zero-length command leads to IDLE.
  - cmd_if.ready depends combinationally on addr_if.ready. No other combinational path exists from inputs to outputs.
- addr_if.data stays stable while valid is high and ready is low (DTI rule). valid never drops before the handshake.
- Address increment is modulo 2**W_ADDR (natural overflow) unless wrap is enabled (see Configuration).
- Length is unsigned. The maximum burst is 2**W_LEN - 1 words.

## Timing
- Reset (rst low, asynchronous): state = IDLE, addr_if.valid = 0, addr = 0, cnt = 0.
- cmd_if.ready = 0 while rst is low. It is 1 in the first cycle after release.
- Latency: a command handshake in cycle N puts the first address valid in cycle N+1.
- Throughput: one address per cycle while addr_if.ready = 1, including across back-to-back commands (no bubble).
- Reset asserted mid-burst: the burst is abandoned immediately and addr_if.valid drops asynchronously. No resume after release.
- A stalled consumer (ready = 0) holds addr, cnt and eot indefinitely.

## Configuration
- Macro SDP_RD_ADDRGEN_WRAP_EN.
- Defined: circular addressing. When addr == DEPTH-1 the next address is 0. Start addresses >= DEPTH are not legal.
- Not defined: DEPTH is ignored. Addresses increment modulo 2**W_ADDR. No compare logic is generated.

## Test plan
- Single burst: cmd {len=4, start=0x10}, ready=1. Addresses 0x10, 0x11, 0x12, 0x13 appear in consecutive cycles starting the cycle after the command. eot=1 only on 0x13.
- Backpressure: cmd {len=3, start=0x20}, ready toggled 1,0,0,1,1. Each address is held stable while stalled. Sequence 0x20, 0x21, 0x22, eot on 0x22, no duplicates or drops.
- Back-to-back: cmd {2, 0x30} then {2, 0x40} presented continuously, ready=1. Output 0x30, 0x31(eot), 0x40, 0x41(eot) with no bubble. The second command is accepted in the cycle 0x31 handshakes.
- Zero length: cmd {len=0, start=0x50} then {len=1, start=0x60}. The first command is consumed with no output. Then a single 0x60 with eot.
- Wrap: W_ADDR=4, cmd {len=3, start=0xE}.
  - Without SDP_RD_ADDRGEN_WRAP_EN: 0xE, 0xF, 0x0.
  - With it and DEPTH=15: 0xE, 0x0, 0x1.
- Reset mid-burst: cmd {len=8, start=0}, assert rst after the third address. addr_if.valid drops immediately. After release, no output until a new command, and cmd_if.ready=1.
